// File: rtl/adt7420_i2c_responder_if.sv
// adt7420_i2c_responder_if: two-wire bus pins between an I2C master and the responder.
//   scl_i  : SCL line level
//   sda_i  : SDA line level (wired-AND of all drivers)
//   sda_oe : responder pulls SDA low when 1
interface adt7420_i2c_responder_if;
    logic scl_i;
    logic sda_i;
    logic sda_oe;
    modport master (output scl_i, output sda_i, input sda_oe);
    modport slave (input scl_i, input sda_i, output sda_oe);
endinterface

// File: rtl/adt7420_i2c_responder.sv
// adt7420_i2c_responder: I2C target emulating the ADT7420 register map.
//   clk_fpga       : system clock, posedge
//   reset          : synchronous, active-high
//   bus            : SCL/SDA levels in, SDA pull-down enable out
//   temp_value     : live temperature word {MSB, LSB}
//   config_reg     : register 0x03
//   soft_rst_pulse : one-cycle pulse on a write to register 0x2F
//   busy           : transaction in progress (START seen, not yet back in IDLE)
module adt7420_i2c_responder #(
    parameter logic [6:0] DEV_ADDR  = 7'h4B,
    parameter logic [7:0] DEVICE_ID = 8'hCB
) (
    input  logic                            clk_fpga,
    input  logic                            reset,
    adt7420_i2c_responder_if.slave          bus,
    input  logic [15:0]                     temp_value,
    output logic [7:0]                      config_reg,
    output logic                            soft_rst_pulse,
    output logic                            busy
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ADDR     = 3'd1;
    localparam logic [2:0] ADDR_ACK = 3'd2;
    localparam logic [2:0] WR_BYTE  = 3'd3;
    localparam logic [2:0] WR_ACK   = 3'd4;
    localparam logic [2:0] RD_BYTE  = 3'd5;
    localparam logic [2:0] RD_ACK   = 3'd6;
    localparam logic [2:0] IGNORE   = 3'd7;

    // [0],[1] synchronize, [2] is history for edge detection
    logic [2:0] scl_q, sda_q;
    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] sh_q, sh_d, ptr_q, ptr_d, cfg_q, cfg_d, shadow_q, shadow_d;
    logic       snap_q, snap_d, first_q, first_d, oe_q, oe_d, pulse_q, pulse_d;
    logic       rise, fall, start, stop, bit_in, load;
    logic [7:0] byte_in, rd_byte;

    assign rise    = scl_q[1] & ~scl_q[2];
    assign fall    = ~scl_q[1] & scl_q[2];
    assign start   = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop    = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
    assign bit_in  = sda_q[1];
    assign byte_in = {sh_q[6:0], bit_in};

    // The LSB snapshot is only honoured when the previous byte of this read burst was 0x00
    assign rd_byte = ptr_q == 8'h00 ? temp_value[15:8] :
                     ptr_q == 8'h01 ? ((snap_q && state_q == RD_ACK) ? shadow_q : temp_value[7:0]) :
                     ptr_q == 8'h03 ? cfg_q :
                     ptr_q == 8'h0B ? DEVICE_ID : 8'h00;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        ptr_d    = ptr_q;
        cfg_d    = cfg_q;
        shadow_d = shadow_q;
        snap_d   = snap_q;
        first_d  = first_q;
        oe_d     = oe_q;
        pulse_d  = 1'b0;
        load     = 1'b0;
        if (start) begin
            state_d = ADDR;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else if (stop) begin
            state_d = IDLE;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (rise) begin
                    sh_d  = byte_in;
                    cnt_d = cnt_q == 4'd7 ? 4'd0 : cnt_q + 4'd1;
                    if (cnt_q == 4'd7) state_d = byte_in[7:1] == DEV_ADDR ? ADDR_ACK : IGNORE;
                end
                // cnt 0: ACK not yet driven; cnt 1: ACK driven, release on the 9th fall
                ADDR_ACK, WR_ACK: if (fall) begin
                    oe_d  = cnt_q == 4'd0;
                    cnt_d = cnt_q == 4'd0 ? 4'd1 : 4'd0;
                    if (cnt_q != 4'd0) begin
                        load    = state_q == ADDR_ACK && sh_q[0];
                        state_d = WR_BYTE;
                        first_d = state_q == ADDR_ACK ? 1'b1 : first_q;
                    end
                end
                WR_BYTE: if (rise) begin
                    sh_d  = byte_in;
                    cnt_d = cnt_q == 4'd7 ? 4'd0 : cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        state_d = WR_ACK;
                        first_d = 1'b0;
                        if (first_q) ptr_d = byte_in;
                        else if (ptr_q == 8'h2F) begin
                            pulse_d = 1'b1;
                            cfg_d   = 8'h00;
                            ptr_d   = 8'h00;
                        end else begin
                            cfg_d = ptr_q == 8'h03 ? byte_in : cfg_q;
                            ptr_d = ptr_q + 8'd1;
                        end
                    end
                end
                RD_BYTE: begin
                    if (rise) cnt_d = cnt_q + 4'd1;
                    if (fall && cnt_q == 4'd8) begin
                        oe_d    = 1'b0;
                        cnt_d   = 4'd0;
                        state_d = RD_ACK;
                        ptr_d   = ptr_q + 8'd1;
                    end else if (fall) begin
                        oe_d = ~sh_q[6];
                        sh_d = {sh_q[6:0], 1'b0};
                    end
                end
                RD_ACK: begin
                    if (rise && bit_in) state_d = IGNORE;
                    else if (rise) cnt_d = 4'd1;
                    load = fall && cnt_q == 4'd1;
                end
                default: ;
            endcase
        end
        if (load) begin
            state_d  = RD_BYTE;
            cnt_d    = 4'd0;
            sh_d     = rd_byte;
            oe_d     = ~rd_byte[7];
            snap_d   = ptr_q == 8'h00;
            shadow_d = ptr_q == 8'h00 ? temp_value[7:0] : shadow_q;
        end
    end

    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            scl_q    <= 3'b111;
            sda_q    <= 3'b111;
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            sh_q     <= 8'h00;
            ptr_q    <= 8'h00;
            cfg_q    <= 8'h00;
            shadow_q <= 8'h00;
            snap_q   <= 1'b0;
            first_q  <= 1'b0;
            oe_q     <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            scl_q    <= {scl_q[1:0], bus.scl_i};
            sda_q    <= {sda_q[1:0], bus.sda_i};
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            ptr_q    <= ptr_d;
            cfg_q    <= cfg_d;
            shadow_q <= shadow_d;
            snap_q   <= snap_d;
            first_q  <= first_d;
            oe_q     <= oe_d;
            pulse_q  <= pulse_d;
        end
    end

    assign bus.sda_oe     = oe_q;
    assign config_reg     = cfg_q;
    assign soft_rst_pulse = pulse_q;
    assign busy           = state_q != IDLE;
endmodule

// File: tb/tb_adt7420_i2c_responder.sv
// tb_adt7420_i2c_responder: directed I2C master transactions against the responder with a read-data scoreboard.
module tb_adt7420_i2c_responder;
    logic        clk_fpga = 1'b0;
    logic        reset = 1'b1;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    logic [15:0] temp_value = 16'h0C80;
    logic [7:0]  config_reg;
    logic        soft_rst_pulse;
    logic        busy;
    int          tests = 0;
    int          fails = 0;
    int          oe_cnt = 0;
    int          pulse_cnt = 0;
    int          snap;
    logic [7:0]  sb[$];

    adt7420_i2c_responder_if bus ();
    assign bus.scl_i = m_scl;
    assign bus.sda_i = m_sda & ~bus.sda_oe;

    adt7420_i2c_responder dut (
        .clk_fpga      (clk_fpga),
        .reset         (reset),
        .bus           (bus),
        .temp_value    (temp_value),
        .config_reg    (config_reg),
        .soft_rst_pulse(soft_rst_pulse),
        .busy          (busy)
    );

    always #5 clk_fpga = ~clk_fpga;

    always @(posedge clk_fpga) begin
        if (bus.sda_oe) oe_cnt <= oe_cnt + 1;
        if (soft_rst_pulse) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic half();
        repeat (10) @(posedge clk_fpga);
        #1;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; half();
        m_scl = 1'b1; half();
        m_sda = 1'b0; half();
        m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; half();
        m_scl = 1'b1; half();
        m_sda = 1'b1; half();
    endtask

    task automatic wbit(input logic b);
        m_sda = b; half();
        m_scl = 1'b1; half();
        m_scl = 1'b0;
    endtask

    task automatic rbit(output logic b);
        m_sda = 1'b1; half();
        m_scl = 1'b1;
        repeat (5) @(posedge clk_fpga);
        #1;
        b = bus.sda_i;
        half();
        m_scl = 1'b0;
    endtask

    task automatic wbyte(input logic [7:0] d, input logic exp_ack, input string tag);
        logic a;
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(a);
        check(tag, 16'(a), 16'(exp_ack));
    endtask

    task automatic rbyte(input logic nack, input string tag);
        logic [7:0] d;
        logic       b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            rbit(b);
            d = {d[6:0], b};
        end
        wbit(nack);
        if (sb.size() == 0) check({tag, "_sb_empty"}, 16'(d), 16'hFFFF);
        else check(tag, 16'(d), 16'(sb.pop_front()));
    endtask

    initial begin
        repeat (3) @(posedge clk_fpga);
        #1;
        check("rst_oe", 16'(bus.sda_oe), 16'h0);
        check("rst_cfg", 16'(config_reg), 16'h00);
        check("rst_pulse", 16'(soft_rst_pulse), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        reset = 1'b0;
        half();
        // wrong address: no ACK, busy until STOP
        snap = oe_cnt;
        i2c_start();
        wbyte(8'h90, 1'b1, "nack_addr");
        wbyte(8'h77, 1'b1, "nack_data");
        check("nack_oe_quiet", 16'(oe_cnt - snap), 16'h0);
        check("nack_busy", 16'(busy), 16'h1);
        i2c_stop();
        check("nack_idle", 16'(busy), 16'h0);
        check("nack_cfg", 16'(config_reg), 16'h00);
        // device ID read with NACK
        i2c_start();
        wbyte(8'h96, 1'b0, "id_addr_w");
        wbyte(8'h0B, 1'b0, "id_ptr");
        i2c_start();
        wbyte(8'h97, 1'b0, "id_addr_r");
        sb.push_back(8'hCB);
        rbyte(1'b1, "id_data");
        snap = oe_cnt;
        half(); half(); half();
        check("id_release", 16'(oe_cnt - snap), 16'h0);
        check("id_busy", 16'(busy), 16'h1);
        i2c_stop();
        // config write and readback
        i2c_start();
        wbyte(8'h96, 1'b0, "cfg_addr");
        wbyte(8'h03, 1'b0, "cfg_ptr");
        wbyte(8'h80, 1'b0, "cfg_data");
        i2c_stop();
        check("cfg_reg", 16'(config_reg), 16'h80);
        i2c_start();
        wbyte(8'h96, 1'b0, "cfgr_addr_w");
        wbyte(8'h03, 1'b0, "cfgr_ptr");
        i2c_start();
        wbyte(8'h97, 1'b0, "cfgr_addr_r");
        sb.push_back(8'h80);
        rbyte(1'b1, "cfgr_data");
        i2c_stop();
        check("cfgr_ptr_end", 16'(dut.ptr_q), 16'h04);
        // temperature snapshot across a two-byte read
        temp_value = 16'h0C80;
        i2c_start();
        wbyte(8'h96, 1'b0, "tmp_addr_w");
        wbyte(8'h00, 1'b0, "tmp_ptr");
        i2c_start();
        wbyte(8'h97, 1'b0, "tmp_addr_r");
        sb.push_back(8'h0C);
        sb.push_back(8'h80);
        rbyte(1'b0, "tmp_msb");
        temp_value = 16'h0D00;
        rbyte(1'b1, "tmp_lsb");
        i2c_stop();
        // pointer wrap 0xFF -> 0x00
        i2c_start();
        wbyte(8'h96, 1'b0, "wrap_addr_w");
        wbyte(8'hFF, 1'b0, "wrap_ptr");
        i2c_start();
        wbyte(8'h97, 1'b0, "wrap_addr_r");
        sb.push_back(8'h00);
        sb.push_back(8'h0D);
        rbyte(1'b0, "wrap_ff");
        rbyte(1'b1, "wrap_00");
        i2c_stop();
        // soft reset register
        snap = pulse_cnt;
        i2c_start();
        wbyte(8'h96, 1'b0, "srst_addr");
        wbyte(8'h2F, 1'b0, "srst_ptr");
        wbyte(8'h00, 1'b0, "srst_data");
        i2c_stop();
        check("srst_pulse_cnt", 16'(pulse_cnt - snap), 16'h1);
        check("srst_cfg", 16'(config_reg), 16'h00);
        i2c_start();
        wbyte(8'h97, 1'b0, "srst_addr_r");
        sb.push_back(8'h0D);
        rbyte(1'b1, "srst_read");
        i2c_stop();
        // reset in the middle of a read
        i2c_start();
        wbyte(8'h96, 1'b0, "mr_cfg_addr");
        wbyte(8'h03, 1'b0, "mr_cfg_ptr");
        wbyte(8'h3C, 1'b0, "mr_cfg_data");
        i2c_stop();
        check("mr_cfg_set", 16'(config_reg), 16'h3C);
        snap = pulse_cnt;
        i2c_start();
        wbyte(8'h96, 1'b0, "mr_addr_w");
        wbyte(8'h0B, 1'b0, "mr_ptr");
        i2c_start();
        wbyte(8'h97, 1'b0, "mr_addr_r");
        for (int i = 0; i < 3; i++) begin
            logic b;
            rbit(b);
        end
        half();
        check("mr_bit4_driven", 16'(bus.sda_oe), 16'h1);
        reset = 1'b1;
        @(posedge clk_fpga);
        #1;
        check("mr_oe", 16'(bus.sda_oe), 16'h0);
        check("mr_busy", 16'(busy), 16'h0);
        check("mr_state", 16'(dut.state_q), 16'h0);
        reset = 1'b0;
        check("mr_cfg_clr", 16'(config_reg), 16'h00);
        check("mr_ptr_clr", 16'(dut.ptr_q), 16'h00);
        check("mr_no_pulse", 16'(pulse_cnt - snap), 16'h0);
        half();
        i2c_stop();
        i2c_start();
        wbyte(8'h96, 1'b0, "post_addr_w");
        wbyte(8'h0B, 1'b0, "post_ptr");
        i2c_start();
        wbyte(8'h97, 1'b0, "post_addr_r");
        sb.push_back(8'hCB);
        rbyte(1'b1, "post_id");
        i2c_stop();
        check("post_idle", 16'(busy), 16'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
